// File: rtl/juice_pkg.sv
// Shared types and constants for the juice vending datapath.
// The dollar codes are produced by juice_machine and are kept here so both blocks agree on them.
package juice_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_WAIT_DROP,
    ST_DONE,
    ST_FAULT
  } disp_state_e;

  typedef enum logic {
    COIN_1,
    COIN_2
  } coin_e;

  localparam int COIN2_VAL = 2;
  localparam int COIN1_VAL = 1;

  localparam logic [2:0] DOLLAR_1 = 3'b001;
  localparam logic [2:0] DOLLAR_2 = 3'b010;
  localparam logic [2:0] DOLLAR_5 = 3'b011;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter with a zero flag.
// A load takes priority; otherwise the count decrements and parks at zero.
module pulse_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Payout controller: pays an owed dollar amount as $2/$1 coins, confirming each coin on the
// exit-chute sensor, and reports completion or a fault (empty hopper or jammed coin).
module change_dispenser
  import juice_pkg::*;
#(
  parameter int AMT_W       = 4,
  parameter int PULSE_CYC   = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             hop2_empty,
  input  logic             hop1_empty,
  input  logic             coin_drop,
  input  logic             fault_clr,
  output logic             eject_2,
  output logic             eject_1,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] paid,
  output logic [AMT_W-1:0] owed_left
);

  // One timer serves both the solenoid pulse and the drop window, so it is sized for the longer.
  localparam int TMR_W = $clog2(max_int(PULSE_CYC, TIMEOUT_CYC) + 1);
  localparam logic [TMR_W-1:0] PULSE_LOAD   = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [AMT_W-1:0] COIN2_AMT    = AMT_W'(COIN2_VAL);
  localparam logic [AMT_W-1:0] COIN1_AMT    = AMT_W'(COIN1_VAL);

  disp_state_e      state_q, state_d;
  logic [AMT_W-1:0] owed_left_q, owed_left_d;
  logic [AMT_W-1:0] paid_q, paid_d;
  coin_e            coin_q, coin_d;
  logic             drop_seen_q, drop_seen_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic             tmr_zero;

  logic             accept;
  logic             sel_coin2;
  logic             sel_coin1;
  logic             drop_now;
  logic [AMT_W-1:0] coin_amt;

  pulse_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .load_val(tmr_load_val),
    .zero    (tmr_zero)
  );

  assign accept    = req_valid & req_ready;
  assign sel_coin2 = (owed_left_q >= COIN2_AMT) & ~hop2_empty;
  assign sel_coin1 = ~hop1_empty;
  // A drop seen earlier in the pulse counts the same as one arriving in its last cycle.
  assign drop_now  = drop_seen_q | coin_drop;
  assign coin_amt  = (coin_q == COIN_2) ? COIN2_AMT : COIN1_AMT;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owed_left_q <= '0;
      paid_q      <= '0;
      coin_q      <= COIN_1;
      drop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owed_left_q <= owed_left_d;
      paid_q      <= paid_d;
      coin_q      <= coin_d;
      drop_seen_q <= drop_seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (owed_left_q == '0) begin
          state_d = ST_DONE;
        end else if (sel_coin2 || sel_coin1) begin
          state_d = ST_EJECT;
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_EJECT: begin
        if (tmr_zero) state_d = drop_now ? ST_SELECT : ST_WAIT_DROP;
      end
      ST_WAIT_DROP: begin
        if (coin_drop) begin
          state_d = ST_SELECT;
        end else if (tmr_zero) begin
          state_d = ST_FAULT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (fault_clr) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Amount bookkeeping, coin choice and timer loads follow the same state decode.
  always_comb begin
    owed_left_d  = owed_left_q;
    paid_d       = paid_q;
    coin_d       = coin_q;
    drop_seen_d  = drop_seen_q;
    tmr_load     = 1'b0;
    tmr_load_val = PULSE_LOAD;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owed_left_d = req_amount;
          paid_d      = '0;
        end
      end
      ST_SELECT: begin
        drop_seen_d = 1'b0;
        if ((owed_left_q != '0) && (sel_coin2 || sel_coin1)) begin
          coin_d       = sel_coin2 ? COIN_2 : COIN_1;
          tmr_load     = 1'b1;
          tmr_load_val = PULSE_LOAD;
        end
      end
      ST_EJECT: begin
        if (coin_drop) drop_seen_d = 1'b1;
        if (tmr_zero) begin
          drop_seen_d = 1'b0;
          if (drop_now) begin
            owed_left_d = owed_left_q - coin_amt;
            paid_d      = paid_q + coin_amt;
          end else begin
            tmr_load     = 1'b1;
            tmr_load_val = TIMEOUT_LOAD;
          end
        end
      end
      ST_WAIT_DROP: begin
        if (coin_drop) begin
          owed_left_d = owed_left_q - coin_amt;
          paid_d      = paid_q + coin_amt;
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE) & rst_n;
    eject_2   = (state_q == ST_EJECT) & (coin_q == COIN_2);
    eject_1   = (state_q == ST_EJECT) & (coin_q == COIN_1);
    done      = (state_q == ST_DONE);
    fault     = (state_q == ST_FAULT);
    paid      = paid_q;
    owed_left = owed_left_q;
  end

endmodule
